sram_req_arbiter: RTL and testbench
===================================

Name: sram_req_arbiter

Overview:
- Shares one SRAM-like memory port (req/addr_ok/data_ok) between the fetch-side inst_sram requester (preIF/IF) and the data_sram requester (EXE/MEM).
- Grants one request per cycle and records the issuing requester in an in-order ID FIFO.
- Routes each returning data_ok/rdata to the requester that owns the oldest outstanding transaction.
- Sits between the CPU core and the SRAM-to-AXI bridge.

Parameters:
- OUTST_DEPTH, 4: maximum outstanding accepted-but-unanswered transactions; power of 2, at least 2.
- STARVE_LIMIT, 8: consecutive data grants allowed while inst waits; used only with ARB_STARVE_EN.

Ports:
- clk  input  1  clock
- resetn  input  1  synchronous active-low reset
- inst_req / inst_wr / inst_size / inst_wstrb / inst_addr / inst_wdata  input  1/1/2/4/32/32  inst requester request fields
- inst_addr_ok / inst_data_ok  output  1/1  inst handshake returns
- inst_rdata  output  32  inst read data
- data_req / data_wr / data_size / data_wstrb / data_addr / data_wdata  input  1/1/2/4/32/32  data requester request fields
- data_addr_ok / data_data_ok  output  1/1  data handshake returns
- data_rdata  output  32  data read data
- mem_req / mem_wr / mem_size / mem_wstrb / mem_addr / mem_wdata  output  1/1/2/4/32/32  shared port request fields
- mem_addr_ok / mem_data_ok  input  1/1  shared port handshake
- mem_rdata  input  32  shared port read data

Behaviour:
- Reset (resetn=0 at posedge clk): ID FIFO empty (rd_ptr=wr_ptr=0, count=0), lock=0, lock_id=0, starve_cnt=0.
  - While resetn=0, mem_req, inst_addr_ok and data_addr_ok are forced 0.
  - Reset mid-transaction drops all outstanding IDs; data_ok arriving after reset is ignored.
- Grant selection, combinational:
  - If lock=1, grant=lock_id.
  - Otherwise grant=DATA if data_req=1, else INST if inst_req=1. Data has fixed priority.
- Request issue:
  - mem_req = (selected requester's req) && (count != OUTST_DEPTH) && resetn.
  - The mem_* request fields mux from the granted requester.
- addr_ok routing: inst_addr_ok = mem_addr_ok && mem_req && grant==INST. data_addr_ok is analogous. The non-granted requester sees addr_ok=0.
- Grant lock:
  - If mem_req=1 and mem_addr_ok=0, set lock<=1 and lock_id<=grant. The request fields therefore stay with one requester until accepted.
  - Clear lock on mem_req && mem_addr_ok.
  - If the locked requester drops req, that is a protocol violation: clear lock and flag it with a simulation-only assertion.
- ID FIFO push: on mem_req && mem_addr_ok, write grant (0=INST, 1=DATA) at wr_ptr, wr_ptr++, count++.
- ID FIFO pop and response routing: on mem_data_ok with count!=0:
  - head=fifo[rd_ptr]; rd_ptr++, count--.
  - inst_data_ok = mem_data_ok && head==INST && count!=0; data_data_ok is analogous.
  - inst_rdata and data_rdata are both driven by mem_rdata, which is valid only with the matching data_ok.
- Simultaneous push and pop in the same cycle: count is unchanged and both pointers advance.
- Full (count==OUTST_DEPTH): mem_req=0, so no addr_ok can be returned to either requester. A pop in the same cycle frees a slot for the next cycle, never the same cycle.
- Empty with mem_data_ok=1: spurious response. Both data_ok outputs stay 0 and the FIFO is unchanged; simulation assertion fires.
- Pointers are log2(OUTST_DEPTH) bits and wrap naturally. count is log2(OUTST_DEPTH)+1 bits.
- Latency:
  - Grant to mem_req is 0 cycles (combinational).
  - Response routing is 0 cycles: data_ok is returned in the same cycle as mem_data_ok.

Optional Feature:
- ARB_STARVE_EN defined:
  - starve_cnt increments on each accepted DATA grant while inst_req=1, and resets on any accepted INST grant or when inst_req=0.
  - When starve_cnt==STARVE_LIMIT and lock=0, grant=INST even if data_req=1.
- ARB_STARVE_EN undefined: starve_cnt is absent and pure data-priority applies.

Decomposition:
- Shared macro header:
  - REQ_ID_INST=1'b0 and REQ_ID_DATA=1'b1.
  - Default OUTST_DEPTH and STARVE_LIMIT values.
- One natural sub-module, arb_id_fifo: a synchronous FIFO parameterised on depth and width (1 bit), with full, empty and count outputs.

Test Plan:
- inst_req=1, addr=0x1C000000; mem_addr_ok the same cycle; mem_data_ok 2 cycles later with rdata=0x02800C0C -> inst_addr_ok=1 in cycle 0; inst_data_ok=1 and inst_rdata=0x02800C0C in cycle 2; data_data_ok stays 0.
- inst_req and data_req both 1, mem_addr_ok=1 -> data wins; next cycle inst is issued; mem_data_ok pulses twice -> data_data_ok first, then inst_data_ok.
- inst_req with mem_addr_ok=0 for 3 cycles, data_req rising in cycle 1 -> mem_addr stays the inst address; after inst is accepted, data is issued the next cycle.
- OUTST_DEPTH=4, issue 4 inst requests with no data_ok -> mem_req=0 on the 5th; one mem_data_ok -> mem_req=1 the next cycle.
- mem_data_ok with FIFO empty -> no data_ok output and no pointer change.
- ARB_STARVE_EN, STARVE_LIMIT=8, data_req and inst_req both held at 1 -> 8 data grants, then 1 inst grant, and the counter restarts.

Source files
------------

// File: rtl/sram_req_arbiter_pkg.sv
// Shared definitions for the SRAM request arbiter: requester IDs, default sizing
// and the bundled request-field record muxed onto the shared memory port.
package sram_req_arbiter_pkg;

  localparam logic REQ_ID_INST = 1'b0;
  localparam logic REQ_ID_DATA = 1'b1;

  localparam int OUTST_DEPTH_DEF  = 4;
  localparam int STARVE_LIMIT_DEF = 8;

  // Field order matches the {wr, size, wstrb, addr, wdata} concatenation of mem_*.
  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  function automatic mem_req_t pack_req(input logic        wr,
                                        input logic [1:0]  size,
                                        input logic [3:0]  wstrb,
                                        input logic [31:0] addr,
                                        input logic [31:0] wdata);
    mem_req_t r;
    r.wr    = wr;
    r.size  = size;
    r.wstrb = wstrb;
    r.addr  = addr;
    r.wdata = wdata;
    return r;
  endfunction

endpackage

// File: rtl/sram_req_arbiter_id_fifo.sv
// arb_id_fifo: small synchronous FIFO holding the requester ID of every accepted,
// not yet answered transaction. Pointers wrap naturally (DEPTH is a power of 2).
module arb_id_fifo
  import sram_req_arbiter_pkg::*;
#(
  parameter int DEPTH = OUTST_DEPTH_DEF,
  parameter int WIDTH = 1,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [PTR_W:0]   o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd_ptr];

  // A pop while full frees the slot only from the next cycle on.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-like port between the inst and data requesters, tracks ownership
// of outstanding transactions in order. Optional starvation guard: ARB_STARVE_EN.
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int OUTST_DEPTH  = OUTST_DEPTH_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W = $clog2(OUTST_DEPTH) + 1;

  logic             r_lock;
  logic             r_lock_id;
  logic             w_grant;
  logic             w_sel_req;
  logic             w_accept;
  logic             w_pop;
  logic             w_head;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  logic             w_starve_force;
  mem_req_t         w_inst_fields;
  mem_req_t         w_data_fields;
  mem_req_t         w_mem_fields;

`ifdef ARB_STARVE_EN
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  logic [SC_W-1:0] r_starve_cnt;

  assign w_starve_force = (r_starve_cnt == SC_W'(STARVE_LIMIT));

  // Counts data grants accepted back-to-back while inst keeps waiting.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_starve_cnt <= '0;
    end else if (!inst_req) begin
      r_starve_cnt <= '0;
    end else if (w_accept && (w_grant == REQ_ID_INST)) begin
      r_starve_cnt <= '0;
    end else if (w_accept && (w_grant == REQ_ID_DATA) && !w_starve_force) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end
`else
  assign w_starve_force = 1'b0;
`endif

  always_comb begin
    w_grant = REQ_ID_INST;
    if (r_lock) begin
      w_grant = r_lock_id;
    end else if (w_starve_force) begin
      w_grant = REQ_ID_INST;
    end else if (data_req) begin
      w_grant = REQ_ID_DATA;
    end
  end

  assign w_inst_fields = pack_req(inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata);
  assign w_data_fields = pack_req(data_wr, data_size, data_wstrb, data_addr, data_wdata);
  assign w_mem_fields  = (w_grant == REQ_ID_DATA) ? w_data_fields : w_inst_fields;
  assign w_sel_req     = (w_grant == REQ_ID_DATA) ? data_req : inst_req;

  assign mem_req   = w_sel_req && !w_full && resetn;
  assign mem_wr    = w_mem_fields.wr;
  assign mem_size  = w_mem_fields.size;
  assign mem_wstrb = w_mem_fields.wstrb;
  assign mem_addr  = w_mem_fields.addr;
  assign mem_wdata = w_mem_fields.wdata;

  assign w_accept     = mem_req && mem_addr_ok;
  assign inst_addr_ok = w_accept && (w_grant == REQ_ID_INST);
  assign data_addr_ok = w_accept && (w_grant == REQ_ID_DATA);

  // Responses come back in issue order, so the FIFO head names the owner.
  assign w_pop        = mem_data_ok && !w_empty;
  assign inst_data_ok = w_pop && (w_head == REQ_ID_INST);
  assign data_data_ok = w_pop && (w_head == REQ_ID_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  // Hold the grant on a stalled request so the mem_* fields cannot switch owner.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_lock    <= 1'b0;
      r_lock_id <= REQ_ID_INST;
    end else if (w_accept) begin
      r_lock <= 1'b0;
    end else if (mem_req) begin
      r_lock    <= 1'b1;
      r_lock_id <= w_grant;
    end else if (r_lock && !w_sel_req) begin
      r_lock <= 1'b0;
    end
  end

  arb_id_fifo #(
    .DEPTH (OUTST_DEPTH),
    .WIDTH (1)
  ) u_id_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (w_accept),
    .i_din   (w_grant),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (resetn) begin
      assert (!(r_lock && !w_sel_req))
        else $error("sram_req_arbiter: locked requester dropped req before addr_ok");
      assert (!(mem_data_ok && w_empty))
        else $warning("sram_req_arbiter: mem_data_ok with no outstanding transaction");
      assert (w_count <= CNT_W'(OUTST_DEPTH))
        else $error("sram_req_arbiter: outstanding count overflow");
      assert (STARVE_LIMIT >= 1)
        else $error("sram_req_arbiter: STARVE_LIMIT must be at least 1");
    end
  end
`endif

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Scoreboard bench for sram_req_arbiter: directed scenarios followed by random traffic,
// checked against a queue-based model of the arbitration rules.
module tb_sram_req_arbiter;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        inst_req = 0, inst_wr = 0, data_req = 0, data_wr = 0;
  logic [1:0]  inst_size = 0, data_size = 0;
  logic [3:0]  inst_wstrb = 0, data_wstrb = 0;
  logic [31:0] inst_addr = 0, inst_wdata = 0, data_addr = 0, data_wdata = 0;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok = 0, mem_data_ok = 0;
  logic [31:0] mem_rdata = 0;

  sram_req_arbiter #(.OUTST_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic owner; logic [31:0] rdata; } resp_t;

  int    checks = 0;
  int    errors = 0;
  int    seq = 0;
  bit    mon_en = 0;
  resp_t sb[$];

  // Requester-side pending transactions (held until accepted).
  bit          ip = 0, dp = 0;
  logic [70:0] ifl, dfl;

  // Reference model: lock state, in-order owner queue, starvation counter.
  bit m_lock = 0, m_lock_id = 0;
  bit m_q[$];
  int m_starve = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit want_i, input bit want_d, input bit aok, input bit dok,
                       input logic [31:0] rd, input bit rst_n);
    bit g, sel, mreq, acc, pop, ireq_now;
    @(posedge clk); #1;
    if (!ip && want_i) begin
      ip  = 1;
      ifl = {1'b0, 2'd2, 4'h0, 32'h1C00_0000 + 32'(seq << 2), 32'($urandom)};
      seq++;
    end
    if (!dp && want_d) begin
      dp  = 1;
      dfl = {1'($urandom), 2'($urandom), 4'($urandom),
             32'h8000_0000 | (32'($urandom) & 32'h0000_FFFC), 32'($urandom)};
    end
    resetn = rst_n;
    inst_req = ip;
    {inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata} = ifl;
    data_req = dp;
    {data_wr, data_size, data_wstrb, data_addr, data_wdata} = dfl;
    mem_addr_ok = aok;
    mem_data_ok = dok;
    mem_rdata   = rd;
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_mem_req", mem_req, 1'b0);
      chk("rst_addr_ok", {inst_addr_ok, data_addr_ok}, 2'b00);
      m_q.delete();
      m_lock = 0; m_lock_id = 0; m_starve = 0;
      return;
    end
    if (m_lock) g = m_lock_id;
`ifdef ARB_STARVE_EN
    else if (m_starve == LIMIT) g = 1'b0;
`endif
    else g = dp;
    sel  = g ? dp : ip;
    mreq = sel && (m_q.size() < DEPTH);
    acc  = mreq && aok;
    pop  = dok && (m_q.size() != 0);
    chk("mem_req", mem_req, mreq);
    if (mreq) chk("mem_fields", {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata}, g ? dfl : ifl);
    chk("inst_addr_ok", inst_addr_ok, acc && !g);
    chk("data_addr_ok", data_addr_ok, acc && g);
    if (pop) sb.push_back('{owner: m_q.pop_front(), rdata: rd});
    ireq_now = ip;
    if (acc) begin
      m_q.push_back(g);
      if (g) dp = 0; else ip = 0;
    end
    if (!ireq_now) m_starve = 0;
    else if (acc && !g) m_starve = 0;
    else if (acc && g && m_starve < LIMIT) m_starve++;
    if (acc) m_lock = 0;
    else if (mreq) begin m_lock = 1; m_lock_id = g; end
  endtask

  // Monitor: every scored response must appear in the same cycle, nothing else may.
  initial begin
    resp_t e;
    forever begin
      @(negedge clk); #1;
      if (mon_en) begin
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("resp_owner", {inst_data_ok, data_data_ok}, e.owner ? 2'b01 : 2'b10);
          chk("resp_rdata", e.owner ? data_rdata : inst_rdata, e.rdata);
        end else begin
          chk("spurious_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
        end
      end
    end
  end

  initial begin
    bit wi, wd, ak, dk, rs;
    // Reset, with an inst request already up to show it is masked.
    cycle(0, 0, 1, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0);
    mon_en = 1;
    cycle(1, 0, 1, 0, 0, 0);
    // Single inst fetch: accepted at once, answered two cycles later.
    cycle(0, 0, 1, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 1, 32'h0280_0C0C, 1);
    // Both request: data first, then inst; responses in the same order.
    cycle(1, 1, 1, 0, 0, 1);
    cycle(0, 0, 1, 0, 0, 1);
    cycle(0, 0, 0, 1, 32'hDA7A_0001, 1);
    cycle(0, 0, 0, 1, 32'h1257_0002, 1);
    // Stalled inst keeps the port while data arrives, data follows acceptance.
    cycle(1, 0, 0, 0, 0, 1);
    cycle(0, 1, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 1, 0, 0, 1);
    cycle(0, 0, 1, 0, 0, 1);
    cycle(0, 0, 0, 1, 32'hAAAA_0003, 1);
    cycle(0, 0, 0, 1, 32'hBBBB_0004, 1);
    // Fill to DEPTH, pop while full, slot reusable only on the following cycle.
    for (int i = 0; i < DEPTH + 1; i++) cycle(1, 0, 1, 0, 0, 1);
    cycle(1, 0, 1, 1, 32'hCCCC_0005, 1);
    cycle(1, 0, 1, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) cycle(0, 0, 0, 1, 32'($urandom), 1);
    // Response with nothing outstanding is dropped.
    cycle(0, 0, 0, 1, 32'hDEAD_BEEF, 1);
    // Reset mid-transaction discards the outstanding ID.
    cycle(0, 1, 1, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 32'h0BAD_0006, 1);
`ifdef ARB_STARVE_EN
    for (int i = 0; i < 2 * LIMIT + 4; i++) cycle(1, 1, 1, 1, 32'($urandom), 1);
`endif
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      wi = ($urandom_range(0, 2) != 0);
      wd = ($urandom_range(0, 2) != 0);
      ak = ($urandom_range(0, 1) == 1);
      rs = ($urandom_range(0, 199) != 0);
      dk = (m_q.size() != 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 15) == 0);
      if (!rs) dk = 0;
      cycle(wi, wd, ak, dk, 32'($urandom), rs);
    end
    for (int i = 0; i < 20 && m_q.size() != 0; i++) cycle(0, 0, 0, 1, 32'($urandom), 1);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    chk("model_drained", 32'(m_q.size()), 32'd0);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
